// File: rtl/rsa_pkg.sv
// Shared constants for the RSA add/sub operand/result feeder.
// Word geometry, FSM state encoding and operation select values.
package rsa_pkg;

  localparam int WIDTH = 32;
  localparam int WORDS = 32;
  localparam int AW    = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Word pointer advance; wraps naturally from WORDS-1 back to 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return AW'(p + 1'b1);
  endfunction

endpackage

// File: rtl/rsa_word_ram.sv
// WORDS x WIDTH register array: one synchronous write port and one
// asynchronous (combinational) read port.
module rsa_word_ram
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  // Write the addressed word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rsa_addsub_feeder.sv
// Operand/result sequencer around the 32-bit word-serial RSA add/sub
// datapath. Holds A and B, streams them word by word with the datapath
// shift strobe, captures result words and the final carry.
// Optional build macro RSA_ADDSUB_ZERO_FLAG_EN adds the oZero output
// (set when every captured result word was zero).
module rsa_addsub_feeder
  import rsa_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iWrEn,
  input  logic             iWrSel,
  input  logic [AW-1:0]    iWrAddr,
  input  logic [WIDTH-1:0] iWrData,
  input  logic             iGo,
  input  logic             iAddSub,
  output logic             oBusy,
  output logic             oStart,
  output logic             oAddSub,
  output logic [WIDTH-1:0] oA,
  output logic [WIDTH-1:0] oB,
  input  logic             iShift,
  input  logic [WIDTH-1:0] iD,
  input  logic             iCout,
  input  logic             iLast,
  input  logic [AW-1:0]    iRdAddr,
  output logic [WIDTH-1:0] oRdData,
  output logic             oCarry,
  output logic             oDone
`ifdef RSA_ADDSUB_ZERO_FLAG_EN
  ,
  output logic             oZero
`endif
);

  logic [1:0]    state_reg;
  logic [AW-1:0] ptr_reg;
  logic          add_sub_reg;
  logic          carry_reg;

  logic          wr_ok;
  logic          a_we;
  logic          b_we;
  logic          r_we;

  // Host writes are only honoured while no operation is in flight.
  assign wr_ok = iWrEn && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign a_we  = wr_ok && !iWrSel;
  assign b_we  = wr_ok &&  iWrSel;

  // Word 0 is shifted in the START cycle itself, so capture covers START and RUN.
  assign r_we  = iShift && (state_reg == ST_START || state_reg == ST_RUN);

  rsa_word_ram u_ram_a (
    .clk   (iClk),
    .we    (a_we),
    .waddr (iWrAddr),
    .wdata (iWrData),
    .raddr (ptr_reg),
    .rdata (oA)
  );

  rsa_word_ram u_ram_b (
    .clk   (iClk),
    .we    (b_we),
    .waddr (iWrAddr),
    .wdata (iWrData),
    .raddr (ptr_reg),
    .rdata (oB)
  );

  rsa_word_ram u_ram_r (
    .clk   (iClk),
    .we    (r_we),
    .waddr (ptr_reg),
    .wdata (iD),
    .raddr (iRdAddr),
    .rdata (oRdData)
  );

  // Sequencer: accept go, pulse start, step pointer on each shift, latch carry on last word.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      add_sub_reg <= OP_ADD;
      carry_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (iGo) begin
            add_sub_reg <= iAddSub;
            ptr_reg     <= '0;
            state_reg   <= ST_START;
          end
        end
        ST_START: begin
          if (iShift) ptr_reg <= ptr_inc(ptr_reg);
          state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (iShift) begin
            ptr_reg <= ptr_inc(ptr_reg);
            if (iLast) begin
              carry_reg <= iCout;
              state_reg <= ST_DONE;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign oStart  = (state_reg == ST_START);
  assign oBusy   = (state_reg == ST_START) || (state_reg == ST_RUN);
  assign oDone   = (state_reg == ST_DONE);
  assign oAddSub = add_sub_reg;
  assign oCarry  = carry_reg;

`ifdef RSA_ADDSUB_ZERO_FLAG_EN
  logic zacc_reg;
  logic d_any;

  assign d_any = |iD;

  // OR-accumulate every shifted result word; publish "all zero" on the last word.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      zacc_reg <= 1'b0;
      oZero    <= 1'b0;
    end else begin
      case (state_reg)
        ST_START: begin
          zacc_reg <= iShift && d_any;
          oZero    <= 1'b0;
        end
        ST_RUN: begin
          if (iShift) begin
            zacc_reg <= zacc_reg || d_any;
            if (iLast) oZero <= !(zacc_reg || d_any);
          end
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rsa_addsub_feeder.sv
// Self-checking bench for rsa_addsub_feeder with a behavioural stand-in
// for the word-serial datapath and a 1024-bit arithmetic reference.
module tb_rsa_addsub_feeder;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iWrEn = 1'b0;
  logic        iWrSel = 1'b0;
  logic [4:0]  iWrAddr = '0;
  logic [31:0] iWrData = '0;
  logic        iGo = 1'b0;
  logic        iAddSub = 1'b0;
  logic        oBusy, oStart, oAddSub, oCarry, oDone;
  logic [31:0] oA, oB, oRdData;
  logic        iShift, iCout, iLast;
  logic [31:0] iD;
  logic [4:0]  iRdAddr = '0;
`ifdef RSA_ADDSUB_ZERO_FLAG_EN
  logic        oZero;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];

  always #5 iClk = ~iClk;

  rsa_addsub_feeder dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWrEn   (iWrEn),
    .iWrSel  (iWrSel),
    .iWrAddr (iWrAddr),
    .iWrData (iWrData),
    .iGo     (iGo),
    .iAddSub (iAddSub),
    .oBusy   (oBusy),
    .oStart  (oStart),
    .oAddSub (oAddSub),
    .oA      (oA),
    .oB      (oB),
    .iShift  (iShift),
    .iD      (iD),
    .iCout   (iCout),
    .iLast   (iLast),
    .iRdAddr (iRdAddr),
    .oRdData (oRdData),
    .oCarry  (oCarry),
    .oDone   (oDone)
`ifdef RSA_ADDSUB_ZERO_FLAG_EN
    ,
    .oZero   (oZero)
`endif
  );

  // Datapath stand-in: 5-bit word counter, carry chain, B inverted for subtract.
  logic [4:0]  dp_cnt;
  logic        dp_carry;
  logic        dp_cin;
  logic [32:0] dp_sum;

  assign iShift = oStart || (dp_cnt != 5'd0);
  assign iLast  = (dp_cnt == 5'd31);
  assign dp_cin = (dp_cnt == 5'd0) ? oAddSub : dp_carry;
  assign dp_sum = {1'b0, oA} + {1'b0, (oAddSub ? ~oB : oB)} + {32'd0, dp_cin};
  assign iD     = dp_sum[31:0];
  assign iCout  = dp_sum[32];

  always @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      dp_cnt   <= 5'd0;
      dp_carry <= 1'b0;
    end else if (iShift) begin
      dp_cnt   <= dp_cnt + 5'd1;
      dp_carry <= dp_sum[32];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < 64; i++) begin
      iWrEn   = 1'b1;
      iWrSel  = (i >= 32);
      iWrAddr = 5'(i % 32);
      iWrData = (i >= 32) ? mb[i-32] : ma[i];
      @(posedge iClk); #1;
    end
    iWrEn = 1'b0;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < 32; i++) begin
      ma[i] = (kind == 0) ? 32'd0 : $urandom;
      mb[i] = (kind == 0) ? 32'd0 : $urandom;
    end
  endtask

  // One operation: go, then follow it cycle by cycle until done (or abort by reset).
  task automatic run_op(input logic op, input bit inject, input int abort_at);
    int starts, busy_n, done_c;
    starts = 0; busy_n = 0; done_c = 0;
    @(posedge iClk); #1;
    iGo = 1'b1; iAddSub = op;
    @(posedge iClk); #1;
    iGo = 1'b0; iAddSub = ~op;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) check("start_at_cycle1", 32'(oStart), 32'd1);
      if (oStart) starts++;
      if (oBusy) busy_n++;
      if (c == abort_at) begin
        #2; iRst = 1'b1; #1;
        check("abort_busy", 32'(oBusy), 32'd0);
        check("abort_start", 32'(oStart), 32'd0);
        check("abort_done", 32'(oDone), 32'd0);
        check("abort_carry", 32'(oCarry), 32'd0);
        check("abort_addsub", 32'(oAddSub), 32'd0);
`ifdef RSA_ADDSUB_ZERO_FLAG_EN
        check("abort_zero", 32'(oZero), 32'd0);
`endif
        @(posedge iClk); #1;
        iRst = 1'b0;
        return;
      end
      if (inject && c == 10) begin
        iGo = 1'b1; iWrEn = 1'b1; iWrSel = 1'b0; iWrAddr = 5'd0; iWrData = 32'hDEADBEEF;
      end
      if (inject && c == 11) begin
        iGo = 1'b0; iWrEn = 1'b0;
      end
      if (oDone) begin
        done_c = c;
        break;
      end
      @(posedge iClk); #1;
    end
    check("done_cycle", 32'(done_c), 32'd33);
    check("start_count", 32'(starts), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'd32);
    check("addsub_latched", 32'(oAddSub), 32'(op));
    $display("run op=%0d inject=%0d done_cycle=%0d starts=%0d", op, inject, done_c, starts);
  endtask

  // Compare captured results with 1024-bit arithmetic on the bench's operand copy.
  task automatic check_results(input logic op);
    logic [1024:0] av, bv, res;
    logic exp_c;
    av = '0; bv = '0;
    for (int i = 0; i < 32; i++) begin
      av[32*i +: 32] = ma[i];
      bv[32*i +: 32] = mb[i];
    end
    if (op) begin
      res   = av - bv;
      exp_c = (av >= bv);
    end else begin
      res   = av + bv;
      exp_c = res[1024];
    end
    for (int i = 0; i < 32; i++) begin
      iRdAddr = 5'(i);
      #1;
      check($sformatf("r_word%0d", i), oRdData, res[32*i +: 32]);
    end
    check("carry", 32'(oCarry), 32'(exp_c));
`ifdef RSA_ADDSUB_ZERO_FLAG_EN
    check("zero", 32'(oZero), 32'(res[1023:0] == '0));
`endif
    $display("results op=%0d carry_exp=%0d r0_exp=%h", op, exp_c, res[31:0]);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge iClk);
    #1;
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_start", 32'(oStart), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_carry", 32'(oCarry), 32'd0);
    check("rst_addsub", 32'(oAddSub), 32'd0);
    iRst = 1'b0;
    @(posedge iClk); #1;

    // Add with full ripple.
    fill(0);
    for (int i = 0; i < 32; i++) ma[i] = 32'hFFFFFFFF;
    mb[0] = 32'd1;
    load_all();
    run_op(1'b0, 1'b0, 0);
    check_results(1'b0);

    // Subtract without borrow.
    fill(0); ma[0] = 32'd5; mb[0] = 32'd3;
    load_all();
    run_op(1'b1, 1'b0, 0);
    check_results(1'b1);

    // Subtract with borrow.
    fill(0); ma[0] = 32'd3; mb[0] = 32'd5;
    load_all();
    run_op(1'b1, 1'b0, 0);
    check_results(1'b1);

    // go and write during a run are ignored.
    fill(1);
    load_all();
    run_op(1'b1, 1'b1, 0);
    check_results(1'b1);
    run_op(1'b0, 1'b0, 0);
    check_results(1'b0);

    // Reset mid-run, then a fresh add.
    run_op(1'b1, 1'b0, 16);
    fill(0); ma[0] = 32'd1; mb[0] = 32'd1;
    load_all();
    run_op(1'b0, 1'b0, 0);
    check_results(1'b0);

    // Back-to-back: second go in the cycle after done.
    fill(1);
    load_all();
    run_op(1'b1, 1'b0, 0);
    run_op(1'b0, 1'b0, 0);
    check_results(1'b0);

    // Random operands and operations.
    for (int k = 0; k < 3; k++) begin
      logic op;
      op = 1'($urandom_range(0, 1));
      fill(1);
      if (k == 2) for (int i = 0; i < 32; i++) mb[i] = ma[i];
      load_all();
      run_op(op, 1'b0, 0);
      check_results(op);
    end

    // Equal operands subtracted: zero result, no borrow.
    load_all();
    run_op(1'b1, 1'b0, 0);
    check_results(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
